// File: rtl/l4_fc_engine.sv
`default_nettype none
// ============================================================================
// Module   : l4_fc_engine
// Purpose  : Layer-4 fully-connected engine. Streams N_IN activations, reads
//            one 16-weight ROM row per activation, multiply-accumulates into
//            16 neuron accumulators, adds the bias row, then hands 16
//            quantised (optionally ReLU'd) results downstream.
// Ports    : clk, rst          - clock / synchronous active-high reset
//            start             - one-cycle pulse, begins an inference in IDLE
//            busy              - high while RUN, BIAS_WAIT, BIAS_ADD
//            in_valid/in_ready/in_data   - activation stream
//            rom_addr          - ROM row base address (16*row)
//            rom_dout          - 16 ROM lanes, one cycle after rom_addr
//            out_valid/out_ready/out_data - 16-lane result handshake
// Revision : 1.0 - initial release
// ============================================================================
module l4_fc_engine #(
    parameter int N_IN       = 400,
    parameter int AW         = 9,
    parameter int WW         = 9,
    parameter int ACCW       = 24,
    parameter int OW         = 9,
    parameter int OUT_SHIFT  = 7,
    parameter int BIAS_SHIFT = 7,
    parameter int RELU       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_data,
    output logic [12:0]            rom_addr,
    input  logic [15:0][WW-1:0]    rom_dout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0][OW-1:0]    out_data
);

    localparam int c_LANES = 16;
    localparam int c_ROWW  = $clog2(N_IN + 1);
    localparam int c_PW    = AW + WW;

    // Saturation window of the output format.
    localparam logic signed [ACCW-1:0] c_out_max = ACCW'((1 << (OW - 1)) - 1);
    localparam logic signed [ACCW-1:0] c_out_min = ~c_out_max;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_BIAS_WAIT = 3'd2,
        S_BIAS_ADD  = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t                  r_state;
    logic [c_ROWW-1:0]       r_row;
    logic [AW-1:0]           r_act_q;
    logic                    r_mac_v;
    logic signed [ACCW-1:0]  r_acc [c_LANES];
    logic                    r_busy;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [15:0][OW-1:0]     r_out_data;

    logic signed [ACCW-1:0]  w_prod_ext [c_LANES];
    logic signed [ACCW-1:0]  w_acc_b    [c_LANES];
    logic [15:0][OW-1:0]     w_q;

    // The ROM samples this address on the same edge that accepts the
    // activation, so its lanes line up with r_act_q one cycle later.
    // In BIAS_WAIT the row counter already equals N_IN, which addresses
    // the bias row without any extra muxing.
    assign rom_addr  = 13'({r_row, 4'b0000});
    assign busy      = r_busy;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    generate
        for (genvar i = 0; i < c_LANES; i++) begin : g_lane
            logic signed [c_PW-1:0] w_a_ext;
            logic signed [c_PW-1:0] w_w_ext;
            logic signed [c_PW-1:0] w_prod;
            logic signed [ACCW-1:0] w_bias_sh;
            logic signed [ACCW-1:0] w_shr;
            logic [OW-1:0]          w_lane_q;

            // Operands are widened to the full product width first so the
            // multiply is exact and signed.
            assign w_a_ext  = {{WW{r_act_q[AW-1]}}, r_act_q};
            assign w_w_ext  = {{AW{rom_dout[i][WW-1]}}, rom_dout[i]};
            assign w_prod   = w_a_ext * w_w_ext;
            assign w_prod_ext[i] = {{(ACCW - c_PW){w_prod[c_PW-1]}}, w_prod};

            assign w_bias_sh  = {{(ACCW - WW){rom_dout[i][WW-1]}}, rom_dout[i]} << BIAS_SHIFT;
            assign w_acc_b[i] = r_acc[i] + w_bias_sh;

            // Quantise the biased sum: floor shift, saturate, optional ReLU.
            assign w_shr = w_acc_b[i] >>> OUT_SHIFT;

            always_comb begin
                w_lane_q = w_shr[OW-1:0];
                if (w_shr > c_out_max) begin
                    w_lane_q = c_out_max[OW-1:0];
                end else if (w_shr < c_out_min) begin
                    w_lane_q = c_out_min[OW-1:0];
                end
                if ((RELU != 0) && w_lane_q[OW-1]) begin
                    w_lane_q = '0;
                end
            end

            assign w_q[i] = w_lane_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_act_q     <= '0;
            r_mac_v     <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int i = 0; i < c_LANES; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_mac_v <= 1'b0;

            // MAC stage for the activation accepted on the previous cycle.
            // It never coincides with the accumulator clear in IDLE or the
            // bias add, so the FSM assignments below cannot conflict.
            if (r_mac_v) begin
                for (int i = 0; i < c_LANES; i++) begin
                    r_acc[i] <= r_acc[i] + w_prod_ext[i];
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < c_LANES; i++) begin
                            r_acc[i] <= '0;
                        end
                        r_row      <= '0;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (in_valid && r_in_ready) begin
                        r_act_q <= in_data;
                        r_mac_v <= 1'b1;
                        r_row   <= r_row + c_ROWW'(1);
                        if (r_row == c_ROWW'(N_IN - 1)) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_BIAS_WAIT;
                        end
                    end
                end

                S_BIAS_WAIT: begin
                    r_state <= S_BIAS_ADD;
                end

                S_BIAS_ADD: begin
                    // Results are captured from the biased sum in the same
                    // edge that commits it, so DONE presents them at once.
                    for (int i = 0; i < c_LANES; i++) begin
                        r_acc[i] <= w_acc_b[i];
                    end
                    r_out_data  <= w_q;
                    r_out_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_row       <= '0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l4_fc_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_l4_fc_engine
// Purpose  : Self-checking bench for l4_fc_engine. Two instances share all
//            inputs: u_relu (RELU=1) and u_lin (RELU=0). Each has its own
//            registered ROM model; expected results come from a behavioural
//            model and are queued in a scoreboard when a run is launched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l4_fc_engine;

    localparam int N = 400;

    typedef logic [15:0][8:0] vec_t;
    typedef struct {
        vec_t relu;
        vec_t lin;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [8:0]  in_data;
    logic        out_ready;

    logic        busy_a, in_ready_a, out_valid_a;
    logic [12:0] rom_addr_a;
    vec_t        rom_dout_a, out_data_a;
    logic        busy_b, in_ready_b, out_valid_b;
    logic [12:0] rom_addr_b;
    vec_t        rom_dout_b, out_data_b;

    int   total = 0;
    int   bad   = 0;
    int   acts [N];
    int   wts  [N+1][16];
    exp_t sb[$];

    always #5 clk = ~clk;

    l4_fc_engine #(.RELU(1)) u_relu (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .rom_addr(rom_addr_a), .rom_dout(rom_dout_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
    );

    l4_fc_engine #(.RELU(0)) u_lin (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .rom_addr(rom_addr_b), .rom_dout(rom_dout_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
    );

    function automatic vec_t rom_row(input logic [12:0] addr);
        vec_t v = '0;
        int   r = int'(addr >> 4);
        if (r <= N) begin
            for (int l = 0; l < 16; l++) v[l] = 9'(wts[r][l]);
        end
        return v;
    endfunction

    // One-cycle-latency ROM for each instance.
    always @(posedge clk) begin
        rom_dout_a <= rom_row(rom_addr_a);
        rom_dout_b <= rom_row(rom_addr_b);
    end

    // Reference: exact integer dot product, wrapped to 24 bits, bias*128,
    // floor divide by 128, clamp to 9-bit signed, optional ReLU.
    function automatic vec_t model(input bit relu);
        vec_t v;
        for (int l = 0; l < 16; l++) begin
            int                 sum;
            logic signed [23:0] acc;
            int                 q;
            sum = 0;
            for (int r = 0; r < N; r++) sum += acts[r] * wts[r][l];
            sum += wts[N][l] * 128;
            acc = sum[23:0];
            q   = acc;
            q   = q >>> 7;
            if (q > 255)  q = 255;
            if (q < -256) q = -256;
            if (relu && q < 0) q = 0;
            v[l] = 9'(q);
        end
        return v;
    endfunction

    task automatic push_expected();
        exp_t e;
        e.relu = model(1'b1);
        e.lin  = model(1'b0);
        sb.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy_a !== 1'b1 || in_ready_a !== 1'b1) begin
            bad++;
            $display("FAIL start_run: busy=%b in_ready=%b want 1 1", busy_a, in_ready_a);
        end
    endtask

    // Feeds activations until stop_at have been offered on a ready cycle.
    // Checks the ROM address seen by each accept.
    task automatic drive_acts(input int stall_pct, input int stop_at, input int pulse_at);
        int k = 0;
        int guard = 0;
        bit pulsed = 0;
        while (k < stop_at && guard < 20000) begin
            in_valid = ($urandom_range(99) >= stall_pct);
            in_data  = 9'(acts[k]);
            start    = (!pulsed && k == pulse_at);
            if (start) pulsed = 1;
            if (in_valid) begin
                total++;
                if (in_ready_a !== 1'b1 || rom_addr_a !== 13'(16 * k) || rom_addr_b !== 13'(16 * k)) begin
                    bad++;
                    $display("FAIL accept_addr k=%0d: ready=%b addr=%0d/%0d want 1 %0d",
                             k, in_ready_a, rom_addr_a, rom_addr_b, 16 * k);
                end
                k++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Tail after the last accept: BIAS_WAIT, BIAS_ADD, then DONE.
    task automatic check_tail();
        int waited = 0;
        total++;
        if (rom_addr_a !== 13'd6400 || in_ready_a !== 1'b0 || busy_a !== 1'b1 || out_valid_a !== 1'b0) begin
            bad++;
            $display("FAIL bias_wait: addr=%0d ready=%b busy=%b ov=%b want 6400 0 1 0",
                     rom_addr_a, in_ready_a, busy_a, out_valid_a);
        end
        @(negedge clk);
        total++;
        if (out_valid_a !== 1'b0 || busy_a !== 1'b1) begin
            bad++;
            $display("FAIL bias_add: ov=%b busy=%b want 0 1", out_valid_a, busy_a);
        end
        do begin
            @(negedge clk);
            waited++;
        end while (out_valid_a !== 1'b1 && waited < 20);
        total++;
        if (waited != 1 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL latency: cycles=%0d busy=%b want 1 0", waited, busy_a);
        end
    endtask

    task automatic collect(input int hold);
        vec_t snap_a, snap_b;
        exp_t e;
        snap_a = out_data_a;
        snap_b = out_data_b;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            total++;
            if (out_valid_a !== 1'b1 || out_data_a !== snap_a || out_data_b !== snap_b) begin
                bad++;
                $display("FAIL hold_stable h=%0d: ov=%b data=%h want 1 %h", h, out_valid_a, out_data_a, snap_a);
            end
        end
        out_ready = 1'b1;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: got output with %0d entries, want 1", sb.size());
        end else begin
            e = sb.pop_front();
            if (out_data_a !== e.relu || out_data_b !== e.lin || out_valid_b !== 1'b1) begin
                bad++;
                $display("FAIL result: relu=%h lin=%h want %h %h", out_data_a, out_data_b, e.relu, e.lin);
            end
        end
        @(negedge clk);
        total++;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL handshake_drop: ov=%b/%b busy=%b want 0 0 0", out_valid_a, out_valid_b, busy_a);
        end
    endtask

    task automatic full_run(input int stall_pct, input int hold, input int pulse_at);
        push_expected();
        out_ready = (hold == 0);
        do_start();
        drive_acts(stall_pct, N, pulse_at);
        check_tail();
        collect(hold);
    endtask

    task automatic set_data(input int w, input int a, input int b);
        for (int r = 0; r < N; r++) begin
            acts[r] = a;
            for (int l = 0; l < 16; l++) wts[r][l] = w;
        end
        for (int l = 0; l < 16; l++) wts[N][l] = b;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 9'd5; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy_a !== 1'b0 || in_ready_a !== 1'b0 || out_valid_a !== 1'b0 ||
            out_data_a !== '0 || rom_addr_a !== 13'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b rdy=%b ov=%b data=%h addr=%0d want all 0",
                     busy_a, in_ready_a, out_valid_a, out_data_a, rom_addr_a);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready_a !== 1'b0 || busy_a !== 1'b0 || rom_addr_a !== 13'd0) begin
            bad++;
            $display("FAIL idle_no_accept: rdy=%b busy=%b addr=%0d want 0 0 0", in_ready_a, busy_a, rom_addr_a);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_all_ones();
        set_data(1, 1, 0);
        full_run(0, 0, -1);
    endtask

    task automatic test_lanes();
        set_data(0, 2, 0);
        for (int r = 0; r < N; r++)
            for (int l = 0; l < 16; l++) wts[r][l] = l - 8;
        full_run(0, 0, -1);
    endtask

    task automatic test_saturation();
        set_data(127, 127, 0);
        wts[N][0] = 1;
        full_run(0, 0, -1);
        set_data(0, 5, 0);
        wts[N][0] = -256;
        full_run(0, 0, -1);
    endtask

    task automatic test_bubbles();
        for (int r = 0; r < N; r++) begin
            acts[r] = int'($urandom_range(60)) - 30;
            for (int l = 0; l < 16; l++) wts[r][l] = int'($urandom_range(80)) - 40;
        end
        for (int l = 0; l < 16; l++) wts[N][l] = int'($urandom_range(100)) - 50;
        full_run(0, 0, -1);
        full_run(50, 10, -1);
    endtask

    task automatic test_start_ignored();
        set_data(1, 1, 0);
        full_run(0, 0, 100);
        set_data(1, -1, 0);
        full_run(0, 0, -1);
    endtask

    task automatic test_reset_mid_run();
        int seen = 0;
        set_data(3, 2, 4);
        out_ready = 1'b1;
        do_start();
        drive_acts(0, 200, -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy_a !== 1'b0 || out_valid_a !== 1'b0 || rom_addr_a !== 13'd0 || in_ready_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_run: busy=%b ov=%b addr=%0d rdy=%b want 0 0 0 0",
                     busy_a, out_valid_a, rom_addr_a, in_ready_a);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid_a === 1'b1 || out_valid_b === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL no_partial: valid cycles=%0d want 0", seen);
        end
        full_run(0, 0, -1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        test_reset();
        test_all_ones();
        test_lanes();
        test_saturation();
        test_bubbles();
        test_start_ignored();
        test_reset_mid_run();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: entries=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l4_fc_engine.md
Name: l4_fc_engine

Overview:
- Layer-4 fully-connected engine; the read-side initiator for the layer-4 weight ROM.
- Accepts a stream of N_IN activations and drives ROM addresses 16 weights (one row) at a time.
- Consumes the 16-lane ROM output with its fixed 1-cycle read latency and multiply-accumulates into 16 neuron accumulators.
- Adds the bias row, then presents 16 quantised (optionally ReLU'd) results to the next layer over a valid/ready handshake.

Parameters:
- N_IN, 400, activations per inference; ROM rows 0..N_IN-1 hold weights, row N_IN holds biases.
- AW, 9, activation width, signed two's complement.
- WW, 9, weight/bias width, signed.
- ACCW, 24, accumulator width, signed.
- OW, 9, output width, signed.
- OUT_SHIFT, 7, arithmetic right shift applied to accumulator before saturation.
- BIAS_SHIFT, 7, left shift applied to sign-extended bias before adding.
- RELU, 1, 1 = clamp negative outputs to 0.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins an inference when in IDLE
- busy  out  1  high in RUN, BIAS_WAIT, BIAS_ADD
- in_valid  in  1  activation valid
- in_ready  out  1  engine accepts activation this cycle
- in_data  in  AW  signed activation
- rom_addr  out  13  ROM row base address = 16*row, combinational from row counter
- rom_dout  in  WW x16  ROM lanes [15:0], valid one cycle after rom_addr is sampled
- out_valid  out  1  results valid, held until accepted
- out_ready  in  1  downstream accepts results
- out_data  out  OW x16  neuron results, lane i = neuron i

Behaviour:
- Reset: state=IDLE, row=0, all accumulators=0, mac_v=0, act_q=0.
- Reset output values: busy=0, in_ready=0, out_valid=0, out_data=all 0, rom_addr=0.
- Reset mid-inference aborts; no partial result is ever emitted.
- States: IDLE, RUN, BIAS_WAIT, BIAS_ADD, DONE.
- IDLE: start=1 -> clear all 16 accumulators, row=0, go RUN. start is ignored in every other state.
- RUN: in_ready=1, rom_addr=16*row.
- On accept (in_valid & in_ready): act_q<=in_data, mac_v<=1, row<=row+1. Otherwise mac_v<=0.
- Pipeline stage: when mac_v=1, acc[i] <= acc[i] + act_q*rom_dout[i], signed, product sign-extended to ACCW, wrap on overflow.
- Throughput is 1 activation/cycle; stalls on in_valid=0 are allowed anywhere.
- Accepting the N_IN-th activation (row becomes N_IN): next state BIAS_WAIT, in_ready=0 from the next cycle.
- BIAS_WAIT: rom_addr=16*N_IN (6400 default); the final MAC for row N_IN-1 completes this cycle; go to BIAS_ADD.
- BIAS_ADD: acc[i] <= acc[i] + (sext(rom_dout[i]) << BIAS_SHIFT); go to DONE.
- DONE: out_valid=1. Each lane gives out_data[i] = sat_OW(acc[i] >>> OUT_SHIFT), then clamped to 0 if RELU=1 and negative.
- Saturation bounds are -2^(OW-1) .. 2^(OW-1)-1.
- out_data is registered on entry to DONE and stable while out_valid=1.
- Handshake completes when out_valid & out_ready; then go IDLE, out_valid=0 next cycle.
- If out_ready is already high on the first DONE cycle, out_valid is high exactly one cycle.
- An in_valid asserted outside RUN is not accepted; in_ready=0.
- Latency from the last accept to out_valid: 3 cycles (BIAS_WAIT, BIAS_ADD, DONE registered).

Test Plan:
- ROM model: all weights 1, biases 0, N_IN=400, 400 activations of 1, out_ready=1 -> acc=400. 400>>>7=3, so all lanes = 3; out_valid high one cycle, 3 cycles after the 400th accept.
- Lane independence: weight lane i = i-8, activations all 2, biases 0 -> acc_i = 800*(i-8), shifted = 6.25*(i-8). Required with RELU=0: lane0 = -50, lane15 = 43 (floor shift). With RELU=1: lanes 0..8 = 0.
- Saturation and bias: weights 127, activations 127, bias lane0 = 1 -> lane0 = 255 (saturated to OW max). With bias = -256, BIAS_SHIFT=7, and weights 0: lane0 = -256.
- Bubbles and backpressure: randomly deassert in_valid (50%) and hold out_ready=0 for 10 cycles in DONE. Required: results identical to the no-stall run, out_data stable while held, and exactly 400 rom_addr values 0,16,...,6384 sampled on accepts, then 6400.
- Start handling: start pulsed during RUN is ignored; the run finishes normally. A second inference after handshake clears the accumulators, so no carryover.
- Reset mid-RUN at row 200: busy=0, out_valid=0, rom_addr=0 next cycle. A fresh start plus a full run gives the correct result.
